// File: rtl/intersection_phase_arbiter.sv
// intersection_phase_arbiter: round-robin green scheduler for four approaches (clock, clear, req[3:0] in; lights[7:0], grant[3:0], phase_start out)
module intersection_phase_arbiter #(
  parameter int MIN_GREEN   = 4,
  parameter int MAX_GREEN   = 10,
  parameter int YEL_TIME    = 3,
  parameter int ALLRED_TIME = 2,
  parameter int CNT_W       = 4
) (
  input  logic       clock,
  input  logic       clear,
  input  logic [3:0] req,
  output logic [7:0] lights,
  output logic [3:0] grant,
  output logic       phase_start
);
  typedef enum logic [1:0] {S_GREEN, S_YELLOW, S_ALLRED} state_t;
  localparam logic [CNT_W-1:0] MIN_END = CNT_W'(MIN_GREEN - 1);
  localparam logic [CNT_W-1:0] MAX_END = CNT_W'(MAX_GREEN - 1);
  localparam logic [CNT_W-1:0] YEL_END = CNT_W'(YEL_TIME - 1);
  localparam logic [CNT_W-1:0] AR_END  = CNT_W'(ALLRED_TIME - 1);
  state_t state, state_n;
  logic [1:0] cur, cur_n, nxt, nxt_n, pick, code_n;
  logic [CNT_W-1:0] timer, timer_n;
  logic [3:0] other;
  logic min_ok, exit_a, exit_b, ps_n;
  always_comb begin
    other = req & ~(4'b0001 << cur);
    min_ok = timer >= MIN_END;
    exit_a = min_ok && |other && (!req[cur] || timer >= MAX_END);
    exit_b = min_ok && ~|other && cur != 2'd0 && !req[cur];
    pick = cur;
    for (int k = 3; k >= 1; k--)
      if (other[cur + 2'(k)]) pick = cur + 2'(k);
    state_n = state;
    cur_n = cur;
    nxt_n = nxt;
    ps_n = 1'b0;
    timer_n = &timer ? timer : timer + CNT_W'(1);
    if (state == S_GREEN && (exit_a || exit_b)) begin
      state_n = S_YELLOW;
      nxt_n = exit_a ? pick : 2'd0;
      timer_n = '0;
    end else if (state == S_YELLOW && timer == YEL_END) begin
      state_n = S_ALLRED;
      timer_n = '0;
    end else if (state == S_ALLRED && timer == AR_END) begin
      state_n = S_GREEN;
      cur_n = nxt;
      timer_n = '0;
      ps_n = 1'b1;
    end
    code_n = state_n == S_GREEN ? 2'd2 : state_n == S_YELLOW ? 2'd1 : 2'd0;
  end
  always_ff @(posedge clock) begin
    if (clear) begin
      state <= S_GREEN;
      cur <= 2'd0;
      nxt <= 2'd0;
      timer <= '0;
      lights <= 8'h02;
      grant <= 4'b0001;
      phase_start <= 1'b0;
    end else begin
      state <= state_n;
      cur <= cur_n;
      nxt <= nxt_n;
      timer <= timer_n;
      lights <= {6'd0, code_n} << {cur_n, 1'b0};
      grant <= 4'b0001 << cur_n;
      phase_start <= ps_n;
    end
  end
endmodule

// File: doc/intersection_phase_arbiter.md
# intersection_phase_arbiter

Phase scheduler for a four-approach intersection. It generalises the two-road highway/country controller: it shares the single "right of way" resource among four approaches. Approach 0 (the main road) rests in green when there is no demand. Green is granted round-robin to approaches whose vehicle sensors are asserted, with minimum- and maximum-green enforcement, a yellow interval and an all-red clearance interval. It sits between the per-approach vehicle sensors and the lamp drivers.

## Interface
- `MIN_GREEN`, 4: minimum green duration, in clocks; must be ≥1.
- `MAX_GREEN`, 10: maximum green duration while another approach waits, in clocks; must be ≥ `MIN_GREEN`.
- `YEL_TIME`, 3: yellow duration, in clocks; must be ≥1.
- `ALLRED_TIME`, 2: all-red clearance duration, in clocks; must be ≥1.
- `CNT_W`, 4: phase timer width; 2^`CNT_W` must exceed every duration parameter.

Ports:
- `clock` input 1: single clock; all state changes on the rising edge.
- `clear` input 1: synchronous, active-high reset.
- `req` input 4: vehicle-present sensor per approach; bit i belongs to approach i; sampled every rising edge.
- `lights` output 8: lamp code per approach; bits [2i+1:2i] belong to approach i. Codes: RED=2'd0, YELLOW=2'd1, GREEN=2'd2; 2'd3 is never driven.
- `grant` output 4: one-hot current owner; valid in every state.
- `phase_start` output 1: one-cycle pulse in the first GREEN cycle after the ALLRED interval.

## Operation
- Registers:
  - `state` ∈ {S_GREEN, S_YELLOW, S_ALLRED}
  - `cur` [1:0]: current owner
  - `nxt` [1:0]: next owner
  - `timer` [CNT_W-1:0]
- The outputs are decoded from registers only. There is no combinational path from `req` to any output.
- `timer` rules:
  - It is 0 on entry to every state.
  - It increments each cycle while the block stays in that state.
  - It saturates at all-ones.
- Define `other = req & ~onehot(cur)` and `min_ok = (timer >= MIN_GREEN-1)`.
- In S_GREEN, exit is taken when `min_ok` and either of the following holds:
  - (a) `other != 0` and (`!req[cur]` or `timer >= MAX_GREEN-1`);
  - (b) `other == 0`, `cur != 0` and `!req[cur]`. In this case the green returns to rest on approach 0.
- On exit:
  - `state` becomes S_YELLOW and `timer` becomes 0.
  - `nxt` is loaded. For (a) it is the first set bit of `other`, scanning `cur+1, cur+2, cur+3` modulo 4. For (b) it is 0.
- Otherwise S_GREEN holds. In particular, approach 0 holds green indefinitely when no other approach requests.
- S_YELLOW: when `timer == YEL_TIME-1`, the next state is S_ALLRED and `timer` becomes 0.
- S_ALLRED: when `timer == ALLRED_TIME-1`, the block does all of the following on that edge:
  - `cur` becomes `nxt`;
  - the next state is S_GREEN;
  - `timer` becomes 0;
  - `phase_start` becomes 1 for the next cycle.
- `req` is ignored in S_YELLOW and S_ALLRED. `nxt` is fixed once it is chosen, even if that request drops; the chosen approach still receives its full `MIN_GREEN`.
- Lamp decode:
  - S_GREEN: `lights[cur]`=GREEN.
  - S_YELLOW: `lights[cur]`=YELLOW.
  - S_ALLRED: all approaches RED.
  - All non-owners are RED in every state.
  - At most one approach is ever non-RED.
- `grant = onehot(cur)` in all states.

## Timing
- Reset values, applied at the first edge with `clear`=1:
  - `state`=S_GREEN, `cur`=0, `nxt`=0, `timer`=0;
  - `lights`=8'b00_00_00_10, `grant`=4'b0001, `phase_start`=0.
- `clear` has priority over every transition, from any state and at any timer value, including mid-yellow and mid-clearance.
- Green occupies at least `MIN_GREEN` cycles. Under contention it occupies at most `MAX_GREEN` cycles. Yellow occupies exactly `YEL_TIME` cycles and all-red exactly `ALLRED_TIME` cycles.
- Hand-over latency, from the edge that samples a qualifying exit to the first GREEN cycle of the new owner, is 1 + `YEL_TIME` + `ALLRED_TIME` - 1 edges. That is 5 edges with the defaults; the new green is visible after the 6th rising edge.
- Requests that arrive simultaneously are resolved purely by the rotate order from `cur+1`. No request is starved: with all four `req` bits held high, owners cycle 0→1→2→3→0.
- A request that rises and falls entirely within yellow or all-red, and is low when S_GREEN is next evaluated, is not served.

## Test plan
- Hold `clear`=1 for 5 negedges, with `req`=0 → after release `lights`=8'h02 and `grant`=4'b0001; both stay constant for 50 clocks.
- `req`=4'b0100 (approach 0 sensor low) asserted while the approach-0 timer is ≥3 → YELLOW on approach 0 for 3 cycles, then `lights`=0 for 2 cycles, then `lights`=8'h20 with `phase_start` pulsed once; when `req`=0 is applied, green returns to approach 0 through the same 3+2 sequence after 4 green cycles.
- `req`=4'b0011 held (owner 0 keeps demand) → approach 0 green lasts exactly 10 cycles, then approach 1 green lasts exactly 10 cycles, then the green returns to approach 0.
- `req`=4'b1111 held → grant sequence 0001→0010→0100→1000→0001, with each green exactly 10 cycles.
- Approach 0 green, `req`=4'b0010 pulsed for one cycle at green timer=1 → no hand-over, because `req` is resampled at timer≥3 when it is low; a pulse held through timer=3 → hand-over to approach 1.
- `clear` asserted in the 2nd YELLOW cycle of approach 2 → next cycle `lights`=8'h02, `grant`=4'b0001, `timer`=0, and no `phase_start` pulse.
